// File: rtl/simon_pkg.sv
// Shared Simon definitions: player FSM states, default timing and memory geometry.
package simon_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StShow = 2'd1,
    StGap  = 2'd2
  } state_t;

  localparam int unsigned ON_CYCLES_DEF  = 50;
  localparam int unsigned OFF_CYCLES_DEF = 25;
  localparam int unsigned DATA_WIDTH_DEF = 4;
  localparam int unsigned ADDR_WIDTH_DEF = 6;

endpackage

// File: rtl/sequence_player_if.sv
// Control and memory-read signals of the sequence player.
interface sequence_player_if #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 4
) ();

    logic                  start;
    logic                  abort;
    logic [ADDR_WIDTH:0]   length;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] leds;
    logic                  busy;
    logic                  done;

    // master is the player itself; slave is the controller/memory side.
    modport master (
        input  start, abort, length, r_data,
        output r_addr, leds, busy, done
    );

    modport slave (
        output start, abort, length, r_data,
        input  r_addr, leds, busy, done
    );

endinterface

// File: rtl/phase_timer.sv
// Loadable up-counter that wraps to zero at a programmable terminal count.
module phase_timer #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_val,
    input  logic                 en,
    input  logic [CNT_WIDTH-1:0] term,
    output logic                 tc
);

    logic [CNT_WIDTH-1:0] cnt_q;

    assign tc = (cnt_q == term);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en) begin
            cnt_q <= tc ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/sequence_player.sv
// Plays back the stored Simon sequence on the LEDs, one entry per ON/OFF period.
module sequence_player
    import simon_pkg::*;
#(
    parameter int unsigned N_ELEMENTS = 64,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ON_CYCLES  = ON_CYCLES_DEF,
    parameter int unsigned OFF_CYCLES = OFF_CYCLES_DEF,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input logic               clk,
    input logic               rst,
    sequence_player_if.master bus
);

    localparam logic [ADDR_WIDTH:0]  LenMax  = (ADDR_WIDTH + 1)'(N_ELEMENTS);
    localparam logic [CNT_WIDTH-1:0] OnTerm  = CNT_WIDTH'(ON_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] OffTerm = CNT_WIDTH'(OFF_CYCLES - 1);

    state_t                state_q;
    logic [ADDR_WIDTH:0]   idx_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic [DATA_WIDTH-1:0] leds_q;
    logic                  done_q;

    logic [ADDR_WIDTH:0]   len_clamped;
    logic                  active;
    logic                  timer_load;
    logic [CNT_WIDTH-1:0]  timer_term;
    logic                  phase_end;

    always_comb begin
        len_clamped = (bus.length > LenMax) ? LenMax : bus.length;
    end

    assign active     = (state_q != StIdle);
    assign timer_load = !active || bus.abort;
    assign timer_term = (state_q == StShow) ? OnTerm : OffTerm;

    phase_timer #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_phase_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val ('0),
        .en       (active),
        .term     (timer_term),
        .tc       (phase_end)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            len_q   <= '0;
            leds_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (active && bus.abort) begin
                // Cancel silently: no completion pulse on abort.
                state_q <= StIdle;
                idx_q   <= '0;
                leds_q  <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        idx_q  <= '0;
                        leds_q <= '0;
                        if (bus.start && !bus.abort) begin
                            if (len_clamped == '0) begin
                                done_q <= 1'b1;
                            end else begin
                                len_q   <= len_clamped;
                                leds_q  <= bus.r_data;
                                state_q <= StShow;
                            end
                        end
                    end
                    StShow: begin
                        if (phase_end) begin
                            leds_q  <= '0;
                            idx_q   <= idx_q + 1'b1;
                            state_q <= StGap;
                        end
                    end
                    StGap: begin
                        if (phase_end) begin
                            if (idx_q == len_q) begin
                                idx_q   <= '0;
                                done_q  <= 1'b1;
                                state_q <= StIdle;
                            end else begin
                                // r_addr already points at the new idx.
                                leds_q  <= bus.r_data;
                                state_q <= StShow;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign bus.r_addr = idx_q[ADDR_WIDTH-1:0];
    assign bus.leds   = leds_q;
    assign bus.busy   = active;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_sequence_player.sv
// Directed bench for sequence_player with ON=3, OFF=2 and a small memory model.
module tb_sequence_player;
    import simon_pkg::*;

    localparam int ON     = 3;
    localparam int OFF    = 2;
    localparam int PERIOD = ON + OFF;

    typedef struct {
        logic       start;
        logic [6:0] length;
        logic [3:0] leds;
        logic       busy;
        logic       done;
        logic [5:0] addr;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic [3:0] mem [64];
    vec_t tbl [17];
    int checks = 0;
    int errors = 0;

    sequence_player_if #(.ADDR_WIDTH(6), .DATA_WIDTH(4)) bus ();

    sequence_player #(
        .N_ELEMENTS(64),
        .ADDR_WIDTH(6),
        .DATA_WIDTH(4),
        .ON_CYCLES (ON),
        .OFF_CYCLES(OFF),
        .CNT_WIDTH (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    assign bus.r_data = mem[bus.r_addr];

    always #5 clk = ~clk;

    task automatic chk(input string name, input int cyc, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int cyc, input logic [3:0] e_leds,
                           input logic e_busy, input logic e_done, input logic [5:0] e_addr);
        chk({tag, ".leds"}, cyc, 32'(bus.leds), 32'(e_leds));
        chk({tag, ".busy"}, cyc, 32'(bus.busy), 32'(e_busy));
        chk({tag, ".done"}, cyc, 32'(bus.done), 32'(e_done));
        chk({tag, ".r_addr"}, cyc, 32'(bus.r_addr), 32'(e_addr));
    endtask

    // Entry at a given cycle after the start edge, derived from the period arithmetic.
    task automatic play(input int len_in, input int len_eff, input string tag);
        logic [3:0] e_leds;
        logic [5:0] e_addr;
        logic       e_busy;
        logic       e_done;
        int         k;
        int         ph;
        bus.start  = 1'b1;
        bus.length = 7'(len_in);
        for (int c = 0; c <= len_eff * PERIOD + 1; c++) begin
            @(negedge clk);
            if (c == 0) bus.start = 1'b0;
            if (c < len_eff * PERIOD) begin
                k      = c / PERIOD;
                ph     = c % PERIOD;
                e_leds = (ph < ON) ? mem[k] : 4'h0;
                e_addr = (ph < ON) ? 6'(k) : 6'((k + 1) % 64);
                e_busy = 1'b1;
                e_done = 1'b0;
            end else begin
                e_leds = 4'h0;
                e_addr = 6'h0;
                e_busy = 1'b0;
                e_done = (c == len_eff * PERIOD);
            end
            chk_all(tag, c, e_leds, e_busy, e_done, e_addr);
        end
    endtask

    task automatic run_table(input logic extra, input string tag);
        for (int c = 0; c < 17; c++) begin
            bus.start  = tbl[c].start || (extra && c == 4);
            bus.length = (extra && c == 4) ? 7'd1 : tbl[c].length;
            @(negedge clk);
            chk_all(tag, c, tbl[c].leds, tbl[c].busy, tbl[c].done, tbl[c].addr);
        end
        bus.start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 4'(1 << (i % 4));

        // Normal length-3 playback, one row per cycle after the start edge.
        tbl[0]  = '{1'b1, 7'd3, 4'h1, 1'b1, 1'b0, 6'd0};
        tbl[1]  = '{1'b0, 7'd3, 4'h1, 1'b1, 1'b0, 6'd0};
        tbl[2]  = '{1'b0, 7'd3, 4'h1, 1'b1, 1'b0, 6'd0};
        tbl[3]  = '{1'b0, 7'd3, 4'h0, 1'b1, 1'b0, 6'd1};
        tbl[4]  = '{1'b0, 7'd3, 4'h0, 1'b1, 1'b0, 6'd1};
        tbl[5]  = '{1'b0, 7'd3, 4'h2, 1'b1, 1'b0, 6'd1};
        tbl[6]  = '{1'b0, 7'd3, 4'h2, 1'b1, 1'b0, 6'd1};
        tbl[7]  = '{1'b0, 7'd3, 4'h2, 1'b1, 1'b0, 6'd1};
        tbl[8]  = '{1'b0, 7'd3, 4'h0, 1'b1, 1'b0, 6'd2};
        tbl[9]  = '{1'b0, 7'd3, 4'h0, 1'b1, 1'b0, 6'd2};
        tbl[10] = '{1'b0, 7'd3, 4'h4, 1'b1, 1'b0, 6'd2};
        tbl[11] = '{1'b0, 7'd3, 4'h4, 1'b1, 1'b0, 6'd2};
        tbl[12] = '{1'b0, 7'd3, 4'h4, 1'b1, 1'b0, 6'd2};
        tbl[13] = '{1'b0, 7'd3, 4'h0, 1'b1, 1'b0, 6'd3};
        tbl[14] = '{1'b0, 7'd3, 4'h0, 1'b1, 1'b0, 6'd3};
        tbl[15] = '{1'b0, 7'd3, 4'h0, 1'b0, 1'b1, 6'd0};
        tbl[16] = '{1'b0, 7'd3, 4'h0, 1'b0, 1'b0, 6'd0};

        rst        = 1'b0;
        bus.start  = 1'b0;
        bus.abort  = 1'b0;
        bus.length = '0;
        repeat (2) @(negedge clk);
        chk_all("reset", 0, 4'h0, 1'b0, 1'b0, 6'd0);
        rst = 1'b1;
        @(negedge clk);

        run_table(1'b0, "normal");
        run_table(1'b1, "start_busy");

        play(0, 0, "zero_len");

        // Abort and start together in IDLE: abort wins, nothing happens.
        bus.start  = 1'b1;
        bus.abort  = 1'b1;
        bus.length = 7'd3;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk_all("idle_abort", 0, 4'h0, 1'b0, 1'b0, 6'd0);
        @(negedge clk);
        chk_all("idle_abort", 1, 4'h0, 1'b0, 1'b0, 6'd0);

        // Abort sampled at E0+4, in the first gap.
        bus.start  = 1'b1;
        bus.length = 7'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk_all("pre_abort", 3, 4'h0, 1'b1, 1'b0, 6'd1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk_all("abort", 4, 4'h0, 1'b0, 1'b0, 6'd0);
        @(negedge clk);
        chk_all("abort", 5, 4'h0, 1'b0, 1'b0, 6'd0);
        play(1, 1, "after_abort");

        // Asynchronous reset between edges during SHOW.
        bus.start  = 1'b1;
        bus.length = 7'd3;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        chk_all("pre_rst", 1, 4'h1, 1'b1, 1'b0, 6'd0);
        #2;
        rst = 1'b0;
        #1;
        chk_all("async_rst", 1, 4'h0, 1'b0, 1'b0, 6'd0);
        @(negedge clk);
        rst = 1'b1;
        play(1, 1, "after_rst");

        play(64, 64, "full64");
        play(100, 64, "clamp100");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
